range_session_arbiter: RTL and testbench
========================================

Name: range_session_arbiter

Overview:
- Shares one min/max range-tracking engine among NUM_REQ requesters.
- Each requester opens a session with req, streams samples, and closes it with data_last.
- The block arbitrates round-robin, clears the tracker, and reports min/max/range tagged with the requester id over a valid/ready result port.
- Sits between sensor front-ends and the range-reporting logic; replaces per-requester range finders.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 10, sample width in bits, unsigned.
- TIMEOUT, 255, consecutive idle cycles inside a session before it aborts (1..65535).

Ports:
- clock, input, 1: sole clock, rising edge.
- reset, input, 1: synchronous, active-low reset.
- req, input, NUM_REQ: requester i wants or holds a session.
- data_in, input, NUM_REQ*WIDTH: requester i sample is at [i*WIDTH +: WIDTH].
- data_valid, input, NUM_REQ: requester i sample is valid this cycle.
- data_last, input, NUM_REQ: qualified by data_valid; marks the final sample of the session.
- grant, output, NUM_REQ: one-hot, the requester currently owning the engine.
- busy, output, 1: high in ACTIVE or DONE.
- res_valid, output, 1: result available; held until accepted.
- res_ready, input, 1: consumer accepts the result.
- res_id, output, $clog2(NUM_REQ): index of the session owner.
- res_min, output, WIDTH: smallest sample of the session.
- res_max, output, WIDTH: largest sample of the session.
- res_range, output, WIDTH: res_max - res_min.
- res_error, output, 1: session ended by abort or timeout.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE.
  - All outputs 0.
  - Round-robin pointer last_id=NUM_REQ-1, so requester 0 has top priority first.
  - Internal min/max, sample counter and idle timer are cleared.
  - Reset mid-session discards the session with no result.
- States: IDLE, ACTIVE, DONE.
- IDLE:
  - If any req bit is set, the winner is the first set bit searching upward from (last_id+1) mod NUM_REQ.
  - Next cycle: state=ACTIVE, grant=onehot(winner), res_id=winner, min=all-ones, max=0, count=0, timer=0.
  - Grant latency from req is 1 cycle.
- ACTIVE:
  - Only the granted lane's data_valid, data_last and data_in are observed; all other lanes are ignored (no buffering).
  - On a granted valid: min<=min(min,d), max<=max(max,d), count increments and saturates, timer=0.
  - Otherwise timer increments.
  - Granted valid with data_last: the sample is included; next state DONE with res_error=0.
  - Granted req falls without a valid last: next state DONE with res_error=1.
  - If the req drop and a valid last occur in the same cycle, last wins and res_error=0.
  - Timer reaching TIMEOUT: next state DONE with res_error=1.
  - data_last without data_valid is ignored.
- DONE:
  - grant=0, res_valid=1.
  - res_min/res_max/res_range/res_id/res_error are registered and stable while res_valid && !res_ready.
  - If count==0 (abort before any sample): res_min=res_max=res_range=0.
  - res_range = max - min, unsigned, WIDTH bits; it is never negative because max>=min when count>0.
  - When res_valid && res_ready: last_id<=res_id, state=IDLE, res_valid=0 next cycle.
  - Back-to-back sessions therefore take at least 1 IDLE cycle.
- req changes during DONE have no effect until IDLE.
- A requester re-asserting req immediately after its session waits behind the other requesters (round-robin fairness).

Optional Feature:
- Macro RANGE_ARB_STATS_EN.
- When defined:
  - Adds output res_count, 16 bits: number of samples accumulated in the session, saturating at 65535, valid with res_valid.
  - Adds output err_total, 8 bits: saturating count of sessions ended with res_error=1, cleared only by reset.
- When undefined: neither port nor the counters exist, and behaviour is otherwise identical.

Test Plan:
- Single session, WIDTH=10:
  - Stimulus: req[1]=1; samples 300,12,845,500, last on 500.
  - Response: grant=0010 1 cycle after req; res_valid with res_id=1, min=12, max=845, range=833, error=0.
- Round-robin:
  - Stimulus: req=1111 held continuously, each session one sample with last, res_ready=1.
  - Response: grants in order 0,1,2,3,0; no lane granted twice in a row.
- Abort and empty session:
  - Abort: req[2] drops after samples 7,9 → res_error=1, min=7, max=9, range=2.
  - Empty: req[3] drops before any sample → min=max=range=0, error=1.
- Timeout and backpressure:
  - Timeout with TIMEOUT=4: no valid for 4 cycles → DONE with error=1.
  - Backpressure: hold res_ready=0 for 10 cycles → outputs stable and grant=0; release → IDLE next cycle.
- Corner cases:
  - Req drop coinciding with a valid last of 1023 after 0 → range=1023, error=0.
  - Non-granted lane valid=1 with data 0 during the session → ignored.
  - reset=0 mid-ACTIVE → all outputs 0 next cycle, and the next grant goes to requester 0.

Source files
------------

// File: rtl/range_session_arbiter.sv
// Round-robin arbiter sharing one min/max range tracker among requesters.
// Ports: clock/reset, per-lane req/data/valid/last, grant, busy, result
//   port (res_valid/res_ready/res_id/res_min/res_max/res_range/res_error);
//   RANGE_ARB_STATS_EN adds res_count and err_total.
module range_session_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 10,
  parameter int TIMEOUT = 255
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   data_in,
  input  logic [NUM_REQ-1:0]         data_valid,
  input  logic [NUM_REQ-1:0]         data_last,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [$clog2(NUM_REQ)-1:0] res_id,
  output logic [WIDTH-1:0]           res_min,
  output logic [WIDTH-1:0]           res_max,
  output logic [WIDTH-1:0]           res_range,
`ifdef RANGE_ARB_STATS_EN
  output logic [15:0]                res_count,
  output logic [7:0]                 err_total,
`endif
  output logic                       res_error
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [15:0] TO = 16'(TIMEOUT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]       state;
  logic [ID_W-1:0]  last_id;
  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] max_q;
  logic [15:0]      count;
  logic [15:0]      timer;

  logic [ID_W-1:0]  win_id;
  logic             win_hit;
  logic             g_req;
  logic             g_valid;
  logic             g_last;
  logic [WIDTH-1:0] g_data;
  logic [15:0]      cnt_inc;
  logic [15:0]      timer_inc;
  logic [WIDTH-1:0] fin_min;
  logic [WIDTH-1:0] fin_max;
  logic [15:0]      fin_cnt;
  logic             fin;
  logic             fin_err;

  // Rotating search: first set req bit at or above last_id+1.
  always_comb begin
    win_id  = '0;
    win_hit = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(last_id) + 1 + k) % NUM_REQ;
      if (!win_hit && req[ID_W'(idx)]) begin
        win_hit = 1'b1;
        win_id  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    g_req     = req[res_id];
    g_valid   = data_valid[res_id];
    g_last    = data_last[res_id];
    g_data    = data_in[res_id*WIDTH +: WIDTH];
    cnt_inc   = (count == 16'hFFFF) ? count : count + 16'd1;
    timer_inc = timer + 16'd1;
    fin_min   = (g_valid && g_data < min_q) ? g_data : min_q;
    fin_max   = (g_valid && g_data > max_q) ? g_data : max_q;
    fin_cnt   = g_valid ? cnt_inc : count;
    fin       = 1'b0;
    fin_err   = 1'b0;
    // A valid last beats a simultaneous req drop.
    if (state == S_ACTIVE) begin
      if (g_valid && g_last) begin
        fin = 1'b1;
      end else if (!g_req) begin
        fin     = 1'b1;
        fin_err = 1'b1;
      end else if (!g_valid && timer_inc == TO) begin
        fin     = 1'b1;
        fin_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      last_id   <= ID_W'(NUM_REQ - 1);
      res_id    <= '0;
      min_q     <= '0;
      max_q     <= '0;
      count     <= '0;
      timer     <= '0;
      res_min   <= '0;
      res_max   <= '0;
      res_range <= '0;
      res_error <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (win_hit) begin
            state  <= S_ACTIVE;
            res_id <= win_id;
            min_q  <= '1;
            max_q  <= '0;
            count  <= '0;
            timer  <= '0;
          end
        end
        S_ACTIVE: begin
          if (g_valid) begin
            min_q <= fin_min;
            max_q <= fin_max;
            count <= cnt_inc;
            timer <= '0;
          end else begin
            timer <= timer_inc;
          end
          if (fin) begin
            state     <= S_DONE;
            res_error <= fin_err;
            if (fin_cnt == 16'd0) begin
              res_min   <= '0;
              res_max   <= '0;
              res_range <= '0;
            end else begin
              res_min   <= fin_min;
              res_max   <= fin_max;
              res_range <= fin_max - fin_min;
            end
          end
        end
        S_DONE: begin
          if (res_ready) begin
            state   <= S_IDLE;
            last_id <= res_id;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RANGE_ARB_STATS_EN
  assign res_count = count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      err_total <= '0;
    end else if (fin && fin_err && err_total != 8'hFF) begin
      err_total <= err_total + 8'd1;
    end
  end
`endif

  assign grant     = (state == S_ACTIVE) ? (NUM_REQ'(1) << res_id) : '0;
  assign busy      = (state != S_IDLE);
  assign res_valid = (state == S_DONE);

endmodule

// File: tb/tb_range_session_arbiter.sv
// Directed scoreboard bench for range_session_arbiter.
// Uses NUM_REQ=4, WIDTH=10, TIMEOUT=4.
module tb_range_session_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [39:0] data_in;
  logic [3:0]  data_valid;
  logic [3:0]  data_last;
  logic [3:0]  grant;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_id;
  logic [9:0]  res_min;
  logic [9:0]  res_max;
  logic [9:0]  res_range;
  logic        res_error;
`ifdef RANGE_ARB_STATS_EN
  logic [15:0] res_count;
  logic [7:0]  err_total;
`endif

  typedef struct {
    int id;
    int mn;
    int mx;
    int rg;
    int err;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  range_session_arbiter #(
    .NUM_REQ(4),
    .WIDTH(10),
    .TIMEOUT(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req(req),
    .data_in(data_in),
    .data_valid(data_valid),
    .data_last(data_last),
    .grant(grant),
    .busy(busy),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_id(res_id),
    .res_min(res_min),
    .res_max(res_max),
    .res_range(res_range),
`ifdef RANGE_ARB_STATS_EN
    .res_count(res_count),
    .err_total(err_total),
`endif
    .res_error(res_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_lane(int i, int v);
    data_in[i*10 +: 10] = 10'(v);
  endtask

  task automatic push(int id, int mn, int mx, int rg, int err);
    exp_t e;
    e.id  = id;
    e.mn  = mn;
    e.mx  = mx;
    e.rg  = rg;
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic wait_result();
    int   n;
    exp_t e;
    n = 0;
    while (res_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("res_valid", 32'(res_valid), 1);
    e = sb.pop_front();
    chk("res_id", 32'(res_id), e.id);
    chk("res_min", 32'(res_min), e.mn);
    chk("res_max", 32'(res_max), e.mx);
    chk("res_range", 32'(res_range), e.rg);
    chk("res_error", 32'(res_error), e.err);
    chk("grant_done", 32'(grant), 0);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    step();
    chk("valid_after_accept", 32'(res_valid), 0);
    chk("busy_after_accept", 32'(busy), 0);
    res_ready = 1'b0;
  endtask

  initial begin
    int sv[4];
    reset      = 1'b0;
    req        = '0;
    data_in    = '0;
    data_valid = '0;
    data_last  = '0;
    res_ready  = 1'b0;
    step();
    step();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_id", 32'(res_id), 0);
    chk("rst_min", 32'(res_min), 0);
    reset = 1'b1;
    step();

    // Single session on lane 1.
    req = 4'b0010;
    step();
    chk("s1_grant", 32'(grant), 4'b0010);
    chk("s1_busy", 32'(busy), 1);
    push(1, 12, 845, 833, 0);
    sv = '{300, 12, 845, 500};
    for (int i = 0; i < 4; i++) begin
      set_lane(1, sv[i]);
      data_valid = 4'b0010;
      data_last  = (i == 3) ? 4'b0010 : 4'b0000;
      step();
    end
    data_valid = '0;
    data_last  = '0;
    req        = '0;
    wait_result();
    accept();

    // Reset mid-session; lane 2 wins before reset.
    req = 4'b0100;
    step();
    chk("rm_grant", 32'(grant), 4'b0100);
    set_lane(2, 5);
    data_valid = 4'b0100;
    step();
    reset = 1'b0;
    step();
    chk("rm_grant0", 32'(grant), 0);
    chk("rm_busy", 32'(busy), 0);
    chk("rm_valid", 32'(res_valid), 0);
    chk("rm_id", 32'(res_id), 0);
    chk("rm_max", 32'(res_max), 0);
    chk("rm_err", 32'(res_error), 0);
    reset      = 1'b1;
    req        = '0;
    data_valid = '0;
    step();

    // Round-robin with all lanes requesting.
    req       = 4'b1111;
    res_ready = 1'b1;
    for (int s = 0; s < 5; s++) begin
      int id;
      id = s % 4;
      step();
      chk("rr_grant", 32'(grant), 32'(1) << id);
      for (int l = 0; l < 4; l++) set_lane(l, 50 * l + s + 1);
      data_valid = 4'b1111;
      data_last  = 4'b1111;
      push(id, 50 * id + s + 1, 50 * id + s + 1, 0, 0);
      step();
      data_valid = '0;
      data_last  = '0;
      if (s == 4) req = '0;
      wait_result();
      step();
      chk("rr_idle", 32'(busy), 0);
    end
    res_ready = 1'b0;

    // Abort on lane 2 with an ignored lane-0 sample of 0.
    req = 4'b0100;
    step();
    chk("ab_grant", 32'(grant), 4'b0100);
    push(2, 7, 9, 2, 1);
    set_lane(0, 0);
    set_lane(2, 7);
    data_valid = 4'b0101;
    step();
    set_lane(2, 9);
    step();
    data_valid = '0;
    req        = '0;
    step();
    wait_result();
    accept();

    // Empty session on lane 3.
    req = 4'b1000;
    step();
    chk("em_grant", 32'(grant), 4'b1000);
    push(3, 0, 0, 0, 1);
    req = '0;
    step();
    wait_result();
    accept();

    // Timeout on lane 0, with a stray last lacking valid.
    req = 4'b0001;
    step();
    chk("to_grant", 32'(grant), 4'b0001);
    set_lane(0, 33);
    data_valid = 4'b0001;
    step();
    data_valid = '0;
    data_last  = 4'b0001;
    push(0, 33, 33, 0, 1);
    for (int i = 0; i < 3; i++) step();
    chk("to_not_yet", 32'(res_valid), 0);
    chk("to_grant_held", 32'(grant), 4'b0001);
    step();
    data_last = '0;
    wait_result();

    // Backpressure; req changes must not matter.
    req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid", 32'(res_valid), 1);
      chk("bp_grant", 32'(grant), 0);
      chk("bp_min", 32'(res_min), 33);
      chk("bp_id", 32'(res_id), 0);
    end
    req = '0;
    accept();

    // Req drop coinciding with a valid last; lane 1 wins after 0.
    req = 4'b0010;
    step();
    chk("cc_grant", 32'(grant), 4'b0010);
    set_lane(1, 0);
    data_valid = 4'b0010;
    step();
    set_lane(1, 1023);
    data_last = 4'b0010;
    req       = '0;
    push(1, 0, 1023, 1023, 0);
    step();
    data_valid = '0;
    data_last  = '0;
    wait_result();
    accept();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
